aes_mask_ctrl: RTL

Sequencer that drives one aes_mask instance through a complete masking operation. It accepts a request carrying key, block and keylen over a valid/ready handshake, then issues the init pulse, the correct number of next pulses and the finalize pulse. It captures the masked result and returns it over a valid/ready response handshake. It sits between the AES core control path and the masking datapath, and is the only driver of that datapath's strobes.

---
 rtl/aes_mask_pkg.sv | 17 +
 rtl/aes_mask_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/aes_mask_pkg.sv
// Shared definitions for the masking controller: state encoding and default
// round counts for the two key schedules.
package aes_mask_pkg;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_INIT  = 3'd1,
    CTRL_NEXT  = 3'd2,
    CTRL_FINAL = 3'd3,
    CTRL_CAPT  = 3'd4,
    CTRL_RESP  = 3'd5
  } ctrl_state_e;

  localparam int AES128_ROUNDS = 10;
  localparam int AES256_ROUNDS = 14;

endpackage

// File: rtl/aes_mask_ctrl.sv
// Sequencer for one aes_mask datapath: init, nrounds next pulses, finalize,
// capture, then return the result. Handshakes: a transfer happens in a cycle
// where valid && ready are both high at the rising clk edge; valid holds until then.
module aes_mask_ctrl
  import aes_mask_pkg::*;
#(
  parameter int ROUNDS_128 = AES128_ROUNDS,
  parameter int ROUNDS_256 = AES256_ROUNDS,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [127:0]     req_key,
  input  logic [127:0]     req_block,
  input  logic             req_keylen,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [127:0]     resp_result,
  input  logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] round,
  output logic [15:0]      ops_done,
  output logic             mask_init,
  output logic             mask_next,
  output logic             mask_finalize,
  output logic [127:0]     mask_key,
  output logic             mask_keylen,
  output logic [127:0]     mask_block,
  input  logic [127:0]     mask_result
);

  localparam logic [CNT_W-1:0] LAST_128 = CNT_W'(ROUNDS_128 - 1);
  localparam logic [CNT_W-1:0] LAST_256 = CNT_W'(ROUNDS_256 - 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [127:0]     key_q, block_q, result_q;
  logic             keylen_q;
  logic [15:0]      ops_q;
  logic [CNT_W-1:0] last_round;
  logic             in_flight;
  logic             accept;
  logic             deliver;

  assign last_round = keylen_q ? LAST_256 : LAST_128;
  assign in_flight  = (state_q == CTRL_INIT) || (state_q == CTRL_NEXT) ||
                      (state_q == CTRL_FINAL) || (state_q == CTRL_CAPT);
  assign accept     = (state_q == CTRL_IDLE) && req_valid;
  assign deliver    = (state_q == CTRL_RESP) && resp_ready;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      CTRL_IDLE: begin
        round_d = '0;
        if (req_valid) state_d = CTRL_INIT;
      end
      CTRL_INIT:  state_d = CTRL_NEXT;
      CTRL_NEXT: begin
        if (round_q == last_round) begin
          round_d = '0;
          state_d = CTRL_FINAL;
        end else begin
          round_d = round_q + CNT_W'(1);
        end
      end
      CTRL_FINAL: state_d = CTRL_CAPT;
      CTRL_CAPT:  state_d = CTRL_RESP;
      CTRL_RESP: begin
        if (resp_ready) state_d = CTRL_IDLE;
      end
      default: begin
        state_d = CTRL_IDLE;
        round_d = '0;
      end
    endcase
    // Once the result is captured it is always delivered, so abort stops at CAPT.
    if (abort && in_flight) begin
      state_d = CTRL_IDLE;
      round_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= CTRL_IDLE;
      round_q  <= '0;
      key_q    <= '0;
      block_q  <= '0;
      keylen_q <= 1'b0;
      result_q <= '0;
      ops_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      if (accept) begin
        key_q    <= req_key;
        block_q  <= req_block;
        keylen_q <= req_keylen;
      end
      if ((state_q == CTRL_CAPT) && !abort) result_q <= mask_result;
      if (deliver && (ops_q != 16'hffff)) ops_q <= ops_q + 16'd1;
    end
  end

  // Control outputs are gated by reset_n so they read 0 for the whole reset window.
  assign req_ready     = (state_q == CTRL_IDLE)  && reset_n;
  assign busy          = (state_q != CTRL_IDLE)  && reset_n;
  assign resp_valid    = (state_q == CTRL_RESP)  && reset_n;
  assign mask_init     = (state_q == CTRL_INIT)  && reset_n;
  assign mask_next     = (state_q == CTRL_NEXT)  && reset_n;
  assign mask_finalize = (state_q == CTRL_FINAL) && reset_n;

  assign round       = round_q;
  assign ops_done    = ops_q;
  assign resp_result = result_q;
  assign mask_key    = key_q;
  assign mask_block  = block_q;
  assign mask_keylen = keylen_q;

endmodule
